// File: rtl/dcache_sized_if.sv
// Uop/data bus between the execute stage and the data cache.
interface dcache_sized_if;
    logic [4:0]  uop;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;

    modport master (
        output uop, addr, data_in,
        input  busy, data_out, data_valid
    );

    modport slave (
        input  uop, addr, data_in,
        output busy, data_out, data_valid
    );
endinterface

// File: rtl/dcache_sized.sv
// Byte-addressed little-endian data cache with sized and sign-extending
// accesses; word-crossing accesses are split over two cycles.
module dcache_sized #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [4:0]  STR_UOP    = 5'b01001,
    parameter logic [4:0]  LDR_UOP    = 5'b01010,
    parameter logic [4:0]  STRB_UOP   = 5'b01011,
    parameter logic [4:0]  LDRB_UOP   = 5'b01100,
    parameter logic [4:0]  STRH_UOP   = 5'b01101,
    parameter logic [4:0]  LDRH_UOP   = 5'b01110,
    parameter logic [4:0]  LDRSB_UOP  = 5'b01111,
    parameter logic [4:0]  LDRSH_UOP  = 5'b10000
) (
    input  logic           clock,
    input  logic           reset,
    dcache_sized_if.slave  bus
);
    localparam int unsigned WORD_BITS = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH     = 1 << WORD_BITS;

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t state, next_state;

    logic [31:0] mem [DEPTH];

    logic                 op_valid, op_load, op_sign;
    logic [2:0]           op_size;
    logic [3:0]           lane_mask;
    logic [ADDR_WIDTH-1:0] a;
    logic [WORD_BITS-1:0] w, w_next;
    logic [1:0]           o;
    logic                 crosses;
    logic [7:0]           be64;
    logic [63:0]          data64;

    logic [31:0]          hold;
    logic [WORD_BITS-1:0] pend_widx;
    logic [3:0]           pend_be_hi;
    logic [31:0]          pend_data_hi;
    logic [1:0]           pend_off;
    logic [2:0]           pend_size;
    logic                 pend_sign, pend_load;

    logic                 mem_we;
    logic [WORD_BITS-1:0] mem_widx;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata;
    logic [31:0]          dout_c;
    logic                 dvalid_c, busy_c, capture_c;

    logic [31:0]          data_out_q;
    logic                 data_valid_q, busy_q;

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;

    // Select the accessed bytes from a two-word window and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [63:0] win, input logic [1:0] off,
                                            input logic [2:0] sz, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(win >> {off, 3'b000});
        case (sz)
            3'd1:    res = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'b0, sh[7:0]};
            3'd2:    res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Uop decode and address/lane alignment.
    always_comb begin
        op_valid  = 1'b0;
        op_load   = 1'b0;
        op_sign   = 1'b0;
        op_size   = 3'd4;
        lane_mask = 4'b1111;
        case (bus.uop)
            STR_UOP:   begin op_valid = 1'b1; op_size = 3'd4; end
            LDR_UOP:   begin op_valid = 1'b1; op_size = 3'd4; op_load = 1'b1; end
            STRB_UOP:  begin op_valid = 1'b1; op_size = 3'd1; end
            LDRB_UOP:  begin op_valid = 1'b1; op_size = 3'd1; op_load = 1'b1; end
            STRH_UOP:  begin op_valid = 1'b1; op_size = 3'd2; end
            LDRH_UOP:  begin op_valid = 1'b1; op_size = 3'd2; op_load = 1'b1; end
            LDRSB_UOP: begin op_valid = 1'b1; op_size = 3'd1; op_load = 1'b1; op_sign = 1'b1; end
            LDRSH_UOP: begin op_valid = 1'b1; op_size = 3'd2; op_load = 1'b1; op_sign = 1'b1; end
            default:   ;
        endcase
        case (op_size)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        a       = bus.addr[ADDR_WIDTH-1:0];
        w       = a[ADDR_WIDTH-1:2];
        w_next  = w + WORD_BITS'(1);
        o       = a[1:0];
        crosses = op_valid && (({1'b0, o} + op_size) > 3'd4);
        be64    = {4'b0000, lane_mask} << o;
        data64  = {32'b0, bus.data_in} << {o, 3'b000};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: enter SPLIT only for a word-crossing access, leave unconditionally.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (crosses) next_state = SPLIT;
            SPLIT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory write port, load result and capture controls for the current state.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = w;
        mem_be    = 4'b0000;
        mem_wdata = 32'b0;
        dout_c    = data_out_q;
        dvalid_c  = 1'b0;
        busy_c    = (next_state == SPLIT);
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                capture_c = crosses;
                if (op_valid && !op_load) begin
                    mem_we    = 1'b1;
                    mem_widx  = w;
                    mem_be    = be64[3:0];
                    mem_wdata = data64[31:0];
                end else if (op_valid && !crosses) begin
                    dout_c   = extract({32'b0, mem[w]}, o, op_size, op_sign);
                    dvalid_c = 1'b1;
                end
            end
            SPLIT: begin
                if (pend_load) begin
                    dout_c   = extract({mem[pend_widx], hold}, pend_off, pend_size, pend_sign);
                    dvalid_c = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_widx  = pend_widx;
                    mem_be    = pend_be_hi;
                    mem_wdata = pend_data_hi;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and the split-access holding state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out_q   <= 32'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            hold         <= 32'b0;
            pend_widx    <= '0;
            pend_be_hi   <= 4'b0000;
            pend_data_hi <= 32'b0;
            pend_off     <= 2'b00;
            pend_size    <= 3'd0;
            pend_sign    <= 1'b0;
            pend_load    <= 1'b0;
        end else begin
            data_out_q   <= dout_c;
            data_valid_q <= dvalid_c;
            busy_q       <= busy_c;
            if (capture_c) begin
                hold         <= mem[w];
                pend_widx    <= w_next;
                pend_be_hi   <= be64[7:4];
                pend_data_hi <= data64[63:32];
                pend_off     <= o;
                pend_size    <= op_size;
                pend_sign    <= op_sign;
                pend_load    <= op_load;
            end
        end
    end

    // Byte-lane write into the storage array; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_be[l]) mem[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end
endmodule
